// File: rtl/cpu10_pkg.sv
// Shared definitions for the 10-bit computer: word width, multiplier
// state encoding and the iteration-counter width.
package cpu10_pkg;

  localparam int WORD_W    = 10;
  localparam int MUL_CNT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add datapath: operand magnitudes, the W+1-bit accumulator, the
// multiplier/quotient shift register and the final sign fix-up.
module mul_datapath #(
  parameter int WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_result
);

  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_mq;
  logic [WIDTH-1:0]   r_mcand;
  logic               r_neg;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_acc_next;
  logic [2*WIDTH-1:0] w_raw;

  // The magnitude of the most negative operand still fits unsigned in W bits.
  always_comb begin
    w_mag_a    = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    w_mag_b    = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
    w_sum      = r_acc + {1'b0, r_mcand};
    w_acc_next = r_mq[0] ? w_sum : r_acc;
    w_raw      = {r_acc[WIDTH-1:0], r_mq};
    o_result   = r_neg ? -w_raw : w_raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_mq    <= '0;
      r_mcand <= '0;
      r_neg   <= 1'b0;
    end else if (i_load) begin
      r_acc   <= '0;
      r_mq    <= w_mag_b;
      r_mcand <= w_mag_a;
      r_neg   <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
    end else if (i_step) begin
      r_acc   <= {1'b0, w_acc_next[WIDTH:1]};
      r_mq    <= {w_acc_next[0], r_mq[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_10bits.sv
// Iterative signed/unsigned multiplier with start/busy/done handshake.
// Handshake: start is taken only in IDLE; done pulses one cycle with a new product.
module mul_10bits
  import cpu10_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mul_state_t         r_state;
  mul_state_t         w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               w_load;
  logic               w_step;
  logic               w_fin;
  logic [2*WIDTH-1:0] w_result;

  mul_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_signed (signed_op),
    .i_a      (a),
    .i_b      (b),
    .o_result (w_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_fin  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        // Last step is the one that takes cnt from 1 to 0.
        if (r_cnt == CNT_W'(1)) w_next = FIN;
      end
      FIN: begin
        w_fin  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cnt <= '0;
    else if (w_load) r_cnt <= CNT_W'(WIDTH);
    else if (w_step) r_cnt <= r_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_done <= w_fin;
      if (w_fin) begin
        r_hi <= w_result[2*WIDTH-1:WIDTH];
        r_lo <= w_result[WIDTH-1:0];
      end
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign prod_hi = r_hi;
  assign prod_lo = r_lo;

endmodule

// File: tb/tb_mul_10bits.sv
// Random and directed bench for mul_10bits with a scoreboard queue and a
// monitor that checks every done pulse against an arithmetic reference.
module tb_mul_10bits;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] prod_hi;
  logic [W-1:0] prod_lo;

  int             chk_cnt = 0;
  int             pass_cnt = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_exp;
  logic           prev_done = 1'b0;

  always #5 clk = ~clk;

  mul_10bits #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .signed_op (signed_op),
    .busy      (busy),
    .done      (done),
    .prod_hi   (prod_hi),
    .prod_lo   (prod_lo)
  );

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    longint px, py, p;
    if (s) begin
      px = longint'($signed(x));
      py = longint'($signed(y));
    end else begin
      px = longint'(x);
      py = longint'(y);
    end
    p = px * py;
    return p[2*W-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive a request at the current negedge; it is only accepted when idle.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    a = x;
    b = y;
    signed_op = s;
    start = 1'b1;
    if (!busy) exp_q.push_back(ref_mul(x, y, s));
  endtask

  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (n < 60) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) nb++;
      if (done) break;
    end
    check("done_seen", done, 1);
  endtask

  always @(negedge clk) begin
    if (done) begin
      check("done_width", prev_done, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("product", {prod_hi, prod_lo}, mon_exp);
      end
    end
    prev_done = done;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, nb, last, k;
    logic [W-1:0] ra, rb;
    logic rs;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", prod_hi, 0);
    check("rst_lo", prod_lo, 0);
    rst = 1'b0;
    @(negedge clk);

    // 3*5: done seen at the 12th negedge after the request (E11), busy for 11.
    issue(10'd3, 10'd5, 1'b0);
    wait_done(n, nb);
    check("latency", n, 12);
    check("busy_cycles", nb, 11);

    issue(10'h3FF, 10'h3FF, 1'b0); wait_done(n, nb);
    issue(10'h3FD, 10'd5,   1'b1); wait_done(n, nb);
    issue(10'h200, 10'h200, 1'b1); wait_done(n, nb);
    issue(10'h000, 10'h3FF, 1'b1); wait_done(n, nb);
    issue(10'h3FF, 10'h001, 1'b0); wait_done(n, nb);

    // A start while busy is dropped; one in the done cycle is accepted.
    issue(10'd7, 10'd9, 1'b0);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("busy_at_e4", busy, 1);
    issue(10'd2, 10'd2, 1'b0);
    wait_done(n, nb);
    issue(10'd2, 10'd2, 1'b0);
    wait_done(n, nb);
    check("b2b_latency", n, 12);

    // Reset mid-operation clears products and suppresses done.
    issue(10'd3, 10'd5, 1'b0);
    wait_done(n, nb);
    issue(10'h3FF, 10'h3FF, 1'b0);
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", prod_hi, 0);
    check("abort_lo", prod_lo, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(10'd1, 10'd0, 1'b0);
    wait_done(n, nb);

    // Random operands with corner values mixed in.
    repeat (40) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rs = 1'($urandom_range(0, 1));
      k  = $urandom_range(0, 7);
      if (k == 0) ra = 10'h200;
      if (k == 1) rb = 10'h3FF;
      if (k == 2) rb = 10'h200;
      issue(ra, rb, rs);
      wait_done(n, nb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // start held high: one accept per W+2 cycles.
    a = W'($urandom_range(0, (1 << W) - 1));
    b = W'($urandom_range(0, (1 << W) - 1));
    signed_op = 1'b1;
    start = 1'b1;
    last = -1;
    for (int c = 0; c < 40; c++) begin
      if (!busy) exp_q.push_back(ref_mul(a, b, signed_op));
      @(negedge clk);
      if (done) begin
        if (last >= 0) check("held_period", c - last, W + 2);
        last = c;
      end
    end
    start = 1'b0;
    wait_done(n, nb);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
